// File: rtl/formula_1_distributor.sv
// rtl/formula_1_distributor.sv - round-robin dispatcher and in-order result collector for formula_1 units
module formula_1_distributor #(
    parameter int N_UNITS = 4,
    parameter int W       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arg_vld,
    output logic                         arg_rdy,
    input  logic [W-1:0]                 a,
    input  logic [W-1:0]                 b,
    input  logic [W-1:0]                 c,
    output logic                         res_vld,
    output logic [W-1:0]                 res,
    output logic [N_UNITS-1:0]           unit_arg_vld,
    output logic [W-1:0]                 unit_a,
    output logic [W-1:0]                 unit_b,
    output logic [W-1:0]                 unit_c,
    input  logic [N_UNITS-1:0]           unit_res_vld,
    input  logic [N_UNITS*W-1:0]         unit_res,
    output logic [$clog2(N_UNITS+1)-1:0] in_flight,
    output logic                         err
);

    localparam int PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int CW = $clog2(N_UNITS + 1);

    logic [N_UNITS-1:0] busy_q, busy_d;
    logic [N_UNITS-1:0] done_q, done_d;
    logic [W-1:0]       slot_q [N_UNITS];
    logic [W-1:0]       slot_d [N_UNITS];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic               res_vld_q, res_vld_d;
    logic [W-1:0]       res_q, res_d;
    logic [N_UNITS-1:0] unit_arg_vld_q, unit_arg_vld_d;
    logic [W-1:0]       unit_a_q, unit_a_d;
    logic [W-1:0]       unit_b_q, unit_b_d;
    logic [W-1:0]       unit_c_q, unit_c_d;
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic               err_q, err_d;
    logic               accept;
    logic               emit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(N_UNITS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registered busy so there is no arg_vld -> arg_rdy path.
    assign arg_rdy = ~busy_q[wr_ptr_q];
    assign accept  = arg_vld & arg_rdy;
    assign emit    = done_q[rd_ptr_q];

    assign res_vld      = res_vld_q;
    assign res          = res_q;
    assign unit_arg_vld = unit_arg_vld_q;
    assign unit_a       = unit_a_q;
    assign unit_b       = unit_b_q;
    assign unit_c       = unit_c_q;
    assign in_flight    = in_flight_q;
    assign err          = err_q;

    // Next-state: capture unit results, emit oldest done tuple, dispatch new tuple.
    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        slot_d         = slot_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        res_vld_d      = 1'b0;
        res_d          = res_q;
        unit_arg_vld_d = '0;
        unit_a_d       = unit_a_q;
        unit_b_d       = unit_b_q;
        unit_c_d       = unit_c_q;
        err_d          = err_q;
        in_flight_d    = in_flight_q + CW'(accept) - CW'(emit);

        // A result is only legal from a unit that is working and has not yet reported.
        for (int i = 0; i < N_UNITS; i++) begin
            if (unit_res_vld[i]) begin
                if (busy_q[i] && !done_q[i]) begin
                    done_d[i] = 1'b1;
                    slot_d[i] = unit_res[i*W +: W];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        // Emit and capture never target the same unit: emit needs done, capture needs ~done.
        if (emit) begin
            res_vld_d        = 1'b1;
            res_d            = slot_q[rd_ptr_q];
            busy_d[rd_ptr_q] = 1'b0;
            done_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ptr_inc(rd_ptr_q);
        end

        // Accept targets a free unit, so it cannot collide with the emitting one.
        if (accept) begin
            unit_arg_vld_d[wr_ptr_q] = 1'b1;
            unit_a_d                 = a;
            unit_b_d                 = b;
            unit_c_d                 = c;
            busy_d[wr_ptr_q]         = 1'b1;
            wr_ptr_d                 = ptr_inc(wr_ptr_q);
        end
    end

    // State registers; reset drops every tuple in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            done_q         <= '0;
            for (int i = 0; i < N_UNITS; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            res_vld_q      <= 1'b0;
            res_q          <= '0;
            unit_arg_vld_q <= '0;
            unit_a_q       <= '0;
            unit_b_q       <= '0;
            unit_c_q       <= '0;
            in_flight_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            slot_q         <= slot_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            res_vld_q      <= res_vld_d;
            res_q          <= res_d;
            unit_arg_vld_q <= unit_arg_vld_d;
            unit_a_q       <= unit_a_d;
            unit_b_q       <= unit_b_d;
            unit_c_q       <= unit_c_d;
            in_flight_q    <= in_flight_d;
            err_q          <= err_d;
        end
    end

endmodule
